div_sequencer: RTL

- Control FSM that drives the iterative signed divider for DIV instructions.
- Accepts a one-cycle start request from the main control unit and drives the divider's 2-bit State code through check, init, iterate and final.
- Watches the divider's 2-bit status, then issues the Hi/Lo write strobe or a divide-by-zero exception.
- Holds Busy so the main control stalls the pipeline until Done.

---
 rtl/div_seq_pkg.sv | 23 ++
 rtl/div_seq_counter.sv | 25 ++
 rtl/div_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state enum, divider State codes and status codes for the DIV sequencer.
package div_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_EVAL, S_INIT, S_ITER, S_FINAL, S_WRITE, S_ZERO
    } state_e;

    localparam logic [1:0] DS_CHECK = 2'b00;
    localparam logic [1:0] DS_INIT  = 2'b01;
    localparam logic [1:0] DS_ITER  = 2'b10;
    localparam logic [1:0] DS_FINAL = 2'b11;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_DONE = 2'b01;
    localparam logic [1:0] ST_ZERO = 2'b10;

    function automatic logic [1:0] ds_of(state_e s);
        return s == S_INIT  ? DS_INIT  :
               s == S_ITER  ? DS_ITER  :
               s == S_FINAL ? DS_FINAL : DS_CHECK;
    endfunction

endpackage

// File: rtl/div_seq_counter.sv
// div_seq_counter: saturating ITER cycle counter with synchronous clear and watchdog limit compare.
module div_seq_counter #(
    parameter int ITER_LIMIT = 40,
    parameter int CNT_W      = 6
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign hit_o = cnt_q == LAST;

    always_comb cnt_d = clr_i ? '0 : (inc_i && !hit_o) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: control FSM sequencing the iterative signed divider for DIV instructions.
// Optional DIVSEQ_ABORT_EN adds an Abort input that cancels a divide in flight.
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int ITER_LIMIT = 40,
    parameter int CNT_W      = 6
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
`ifdef DIVSEQ_ABORT_EN
    input  logic       Abort,
`endif
    input  logic [1:0] DivStatus,
    output logic [1:0] DivState,
    output logic       HiLoWrite,
    output logic       DivZero,
    output logic       Timeout,
    output logic       Busy,
    output logic       Done
);

    state_e     state_q, state_d;
    logic       to_q, to_d;
    logic       hit, abort_hit, abort_done;
    logic [1:0] ds_q;
    logic       hilo_q, zero_q, tmo_q, busy_q, done_q;

`ifdef DIVSEQ_ABORT_EN
    assign abort_hit = Abort && state_q != S_IDLE;
`else
    assign abort_hit = 1'b0;
`endif
    // An abort in WRITE/ZERO already has its Done pulse in flight; do not pulse twice.
    assign abort_done = abort_hit && state_q != S_WRITE && state_q != S_ZERO;

    div_seq_counter #(.ITER_LIMIT(ITER_LIMIT), .CNT_W(CNT_W)) u_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .clr_i (state_q == S_INIT),
        .inc_i (state_q == S_ITER),
        .hit_o (hit)
    );

    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE:  state_d = Start ? S_CHECK : S_IDLE;
            S_CHECK: state_d = S_EVAL;
            S_EVAL:  state_d = DivStatus == ST_ZERO ? S_ZERO : S_INIT;
            S_INIT: begin
                state_d = S_ITER;
                to_d    = 1'b0;
            end
            S_ITER: begin
                state_d = (DivStatus == ST_DONE || hit) ? S_FINAL : S_ITER;
                to_d    = hit && DivStatus != ST_DONE;
            end
            S_FINAL: state_d = S_WRITE;
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) begin
            state_d = S_IDLE;
            to_d    = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            state_q <= S_IDLE;
            to_q    <= 1'b0;
            ds_q    <= DS_CHECK;
            hilo_q  <= 1'b0;
            zero_q  <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            ds_q    <= ds_of(state_d);
            hilo_q  <= state_d == S_WRITE;
            zero_q  <= state_d == S_ZERO;
            tmo_q   <= state_d == S_WRITE && to_d;
            busy_q  <= state_d != S_IDLE || abort_done;
            done_q  <= state_d == S_WRITE || state_d == S_ZERO || abort_done;
        end

    assign DivState  = ds_q;
    assign HiLoWrite = hilo_q;
    assign DivZero   = zero_q;
    assign Timeout   = tmo_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule
